// File: rtl/s32x_sdram_resp_pkg.sv
// Shared types for the 32X SH-2 SDRAM responder: FSM state encoding and the
// read data returned when an access times out.
package s32x_sdram_resp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] SDR_TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/s32x_sdram_resp_if.sv
// Bus bundles for the responder: the SH-2 side SDRAM request bus and the
// generic req/ack memory channel towards the board SDRAM controller.
interface s32x_sdr_if;
    import s32x_sdram_resp_pkg::*;

    logic [16:0] SDR_A;
    logic [15:0] SDR_DO;
    logic [15:0] SDR_DI;
    logic        SDR_CS;
    logic [1:0]  SDR_WE;
    logic        SDR_RD;
    logic        SDR_WAIT;

    modport master (
        output SDR_A, SDR_DO, SDR_CS, SDR_WE, SDR_RD,
        input  SDR_DI, SDR_WAIT
    );

    modport slave (
        input  SDR_A, SDR_DO, SDR_CS, SDR_WE, SDR_RD,
        output SDR_DI, SDR_WAIT
    );
endinterface

interface s32x_mem_if #(
    parameter int MEM_AW = 24
);
    logic [MEM_AW-1:0] MEM_A;
    logic [15:0]       MEM_WDATA;
    logic [15:0]       MEM_RDATA;
    logic [1:0]        MEM_BE;
    logic              MEM_WR;
    logic              MEM_REQ;
    logic              MEM_ACK;

    modport master (
        output MEM_A, MEM_WDATA, MEM_BE, MEM_WR, MEM_REQ,
        input  MEM_RDATA, MEM_ACK
    );

    modport slave (
        input  MEM_A, MEM_WDATA, MEM_BE, MEM_WR, MEM_REQ,
        output MEM_RDATA, MEM_ACK
    );
endinterface

// File: rtl/s32x_sdram_resp.sv
// Responder for one 32X core's SH-2 SDRAM requests: latches a word request,
// runs it on the req/ack memory channel and holds WAIT until it completes.
//
// state  | meaning
// S_IDLE | no access in flight, waiting for a strobe while armed
// S_REQ  | MEM_REQ high, waiting for MEM_ACK or timeout
// S_DONE | access finished, WAIT low; waits for strobes to drop (re-arm)
module s32x_sdram_resp
    import s32x_sdram_resp_pkg::*;
#(
    parameter int                MEM_AW  = 24,
    parameter logic [MEM_AW-1:0] BASE    = '0,
    parameter int                TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST_N,
    s32x_sdr_if.slave     sdr,
    s32x_mem_if.master    mem,
    output logic          ERR
);

    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_armed;
    logic [CW-1:0]     r_cnt;
    logic [15:0]       r_di;
    logic              r_req;
    logic              r_wr;
    logic [1:0]        r_be;
    logic [MEM_AW-1:0] r_a;
    logic [15:0]       r_wdata;
    logic              r_err;

    logic w_strobe;
    logic w_new_req;
    logic w_timeout;
    logic w_start;
    logic w_ack_done;
    logic w_to_done;

    assign w_strobe  = sdr.SDR_CS & (sdr.SDR_RD | (|sdr.SDR_WE));
    assign w_new_req = w_strobe & r_armed;
    assign w_timeout = (CW'(r_cnt + 1'b1) == TO_VAL);

    assign sdr.SDR_WAIT  = w_new_req | (r_state == S_REQ);
    assign sdr.SDR_DI    = r_di;
    assign mem.MEM_A     = r_a;
    assign mem.MEM_WDATA = r_wdata;
    assign mem.MEM_BE    = r_be;
    assign mem.MEM_WR    = r_wr;
    assign mem.MEM_REQ   = r_req;
    assign ERR           = r_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // DONE accepts a fresh strobe once re-armed, so a quick re-raise is not lost.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ack_done  = 1'b0;
        w_to_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_new_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem.MEM_ACK) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_timeout) begin
                    w_to_done   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (r_armed) begin
                    if (w_new_req) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_armed <= 1'b1;
            r_cnt   <= '0;
            r_di    <= '0;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_be    <= '0;
            r_a     <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_ack_done || w_to_done) r_armed <= 1'b0;
            else if (!w_strobe)          r_armed <= 1'b1;

            if (w_start) begin
                r_a     <= BASE + MEM_AW'(sdr.SDR_A);
                r_wdata <= sdr.SDR_DO;
                r_wr    <= |sdr.SDR_WE;
                r_be    <= (|sdr.SDR_WE) ? sdr.SDR_WE : 2'b11;
                r_req   <= 1'b1;
                r_cnt   <= '0;
            end else if (r_state == S_REQ) begin
                r_cnt <= CW'(r_cnt + 1'b1);
            end

            if (w_ack_done) begin
                r_req <= 1'b0;
                if (!r_wr) r_di <= mem.MEM_RDATA;
            end else if (w_to_done) begin
                r_req <= 1'b0;
                r_di  <= SDR_TIMEOUT_DATA;
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_s32x_sdram_resp.sv
// Scoreboard bench for s32x_sdram_resp: directed accesses push expected
// requests/completions; a negedge monitor pops and compares them.
module tb_s32x_sdram_resp;
    import s32x_sdram_resp_pkg::*;

    localparam int TO1 = 8;

    typedef struct {
        logic [23:0] a;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } req_t;

    typedef struct {
        logic [15:0] di;
        logic        err;
    } cmp_t;

    logic CLK;
    logic RST_N;
    logic err1;
    logic err2;

    s32x_sdr_if                 sdr1 ();
    s32x_mem_if #(.MEM_AW(24))  mem1 ();
    s32x_sdr_if                 sdr2 ();
    s32x_mem_if #(.MEM_AW(17))  mem2 ();

    s32x_sdram_resp #(.MEM_AW(24), .BASE(24'h020000), .TIMEOUT(TO1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .sdr(sdr1.slave), .mem(mem1.master), .ERR(err1)
    );

    s32x_sdram_resp #(.MEM_AW(17), .BASE(17'h0), .TIMEOUT(255)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .sdr(sdr2.slave), .mem(mem2.master), .ERR(err2)
    );

    int   total = 0;
    int   bad   = 0;
    int   n_req = 0;
    req_t exp_req[$];
    cmp_t exp_cmp[$];
    logic m_req_q  = 1'b0;
    logic m_wait_q = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST_N) begin
            m_req_q  = 1'b0;
            m_wait_q = 1'b0;
        end else begin
            if (mem1.MEM_REQ && !m_req_q) begin
                req_t r;
                n_req++;
                chk("req_expected", 32'(exp_req.size() != 0), 32'd1);
                if (exp_req.size() != 0) begin
                    r = exp_req.pop_front();
                    chk("mem_a", 32'(mem1.MEM_A), 32'(r.a));
                    chk("mem_wr", 32'(mem1.MEM_WR), 32'(r.wr));
                    chk("mem_be", 32'(mem1.MEM_BE), 32'(r.be));
                    chk("mem_wdata", 32'(mem1.MEM_WDATA), 32'(r.wdata));
                end
            end
            if (!sdr1.SDR_WAIT && m_wait_q) begin
                cmp_t c;
                chk("cmp_expected", 32'(exp_cmp.size() != 0), 32'd1);
                if (exp_cmp.size() != 0) begin
                    c = exp_cmp.pop_front();
                    chk("sdr_di", 32'(sdr1.SDR_DI), 32'(c.di));
                    chk("err", 32'(err1), 32'(c.err));
                end
            end
            m_req_q  = mem1.MEM_REQ;
            m_wait_q = sdr1.SDR_WAIT;
        end
    end

    task automatic drop_strobes();
        sdr1.SDR_CS = 1'b0;
        sdr1.SDR_RD = 1'b0;
        sdr1.SDR_WE = 2'b00;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(mem1.MEM_REQ), 32'd0);
        chk({tag, "_mem_wr"}, 32'(mem1.MEM_WR), 32'd0);
        chk({tag, "_mem_be"}, 32'(mem1.MEM_BE), 32'd0);
        chk({tag, "_mem_a"}, 32'(mem1.MEM_A), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem1.MEM_WDATA), 32'd0);
        chk({tag, "_sdr_di"}, 32'(sdr1.SDR_DI), 32'd0);
        chk({tag, "_sdr_wait"}, 32'(sdr1.SDR_WAIT), 32'd0);
        chk({tag, "_err"}, 32'(err1), 32'd0);
    endtask

    // ack_dly < 0 means no acknowledge: the access must time out.
    task automatic do_access(input logic [16:0] a, input logic [15:0] dout, input logic [1:0] we,
                             input logic rd, input int ack_dly, input logic [15:0] rdata,
                             input int hold, input bit drop_early,
                             input logic [23:0] e_a, input logic [1:0] e_be, input logic e_wr,
                             input logic [15:0] e_di, input logic e_err);
        exp_req.push_back('{a: e_a, wr: e_wr, be: e_be, wdata: dout});
        exp_cmp.push_back('{di: e_di, err: e_err});
        @(posedge CLK) #1;
        sdr1.SDR_A  = a;
        sdr1.SDR_DO = dout;
        sdr1.SDR_WE = we;
        sdr1.SDR_RD = rd;
        sdr1.SDR_CS = 1'b1;
        #1 chk("wait_same_cycle", 32'(sdr1.SDR_WAIT), 32'd1);
        @(posedge CLK) #1;
        chk("req_latency", 32'(mem1.MEM_REQ), 32'd1);
        if (drop_early) drop_strobes();
        if (ack_dly >= 0) begin
            repeat (ack_dly) @(posedge CLK) #1;
            mem1.MEM_ACK   = 1'b1;
            mem1.MEM_RDATA = rdata;
            @(posedge CLK) #1;
            mem1.MEM_ACK   = 1'b0;
            mem1.MEM_RDATA = 16'h0000;
            chk("req_drop_after_ack", 32'(mem1.MEM_REQ), 32'd0);
            chk("wait_after_ack", 32'(sdr1.SDR_WAIT), 32'd0);
        end else begin
            repeat (TO1 - 1) @(posedge CLK) #1;
            chk("req_high_to_limit", 32'(mem1.MEM_REQ), 32'd1);
            @(posedge CLK) #1;
            chk("req_drop_timeout", 32'(mem1.MEM_REQ), 32'd0);
            chk("wait_after_timeout", 32'(sdr1.SDR_WAIT), 32'd0);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK) #1;
            chk("wait_low_held", 32'(sdr1.SDR_WAIT), 32'd0);
        end
        drop_strobes();
        @(posedge CLK) #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0;
        drop_strobes();
        sdr1.SDR_A = '0; sdr1.SDR_DO = '0;
        mem1.MEM_ACK = 1'b0; mem1.MEM_RDATA = '0;
        sdr2.SDR_A = '0; sdr2.SDR_DO = '0; sdr2.SDR_CS = 1'b0; sdr2.SDR_RD = 1'b0; sdr2.SDR_WE = 2'b00;
        mem2.MEM_ACK = 1'b0; mem2.MEM_RDATA = '0;

        repeat (3) @(posedge CLK);
        #1 check_all_zero("reset");
        RST_N = 1'b1;

        //         a          dout      we     rd ack rdata     hold drop  exp_a        be     wr exp_di    err
        do_access(17'h00010, 16'h0000, 2'b00, 1, 3,  16'hBEEF, 0,   0,    24'h020010, 2'b11, 0, 16'hBEEF, 0);
        do_access(17'h00005, 16'h1234, 2'b01, 0, 1,  16'hDEAD, 0,   0,    24'h020005, 2'b01, 1, 16'hBEEF, 0);
        do_access(17'h00020, 16'h0000, 2'b00, 1, 0,  16'h5A5A, 10,  0,    24'h020020, 2'b11, 0, 16'h5A5A, 0);
        do_access(17'h00021, 16'h0000, 2'b00, 1, 2,  16'hA5A5, 0,   0,    24'h020021, 2'b11, 0, 16'hA5A5, 0);
        do_access(17'h1FFFF, 16'hCAFE, 2'b10, 1, 0,  16'h0BAD, 0,   0,    24'h03FFFF, 2'b10, 1, 16'hA5A5, 0);
        do_access(17'h00003, 16'h0000, 2'b00, 1, 7,  16'h7777, 0,   0,    24'h020003, 2'b11, 0, 16'h7777, 0);
        do_access(17'h00100, 16'h0000, 2'b00, 1, -1, 16'h0000, 0,   0,    24'h020100, 2'b11, 0, 16'hFFFF, 1);
        do_access(17'h00002, 16'h0000, 2'b00, 1, 1,  16'h1111, 0,   0,    24'h020002, 2'b11, 0, 16'h1111, 1);
        do_access(17'h00004, 16'h0000, 2'b00, 1, 2,  16'h4444, 0,   1,    24'h020004, 2'b11, 0, 16'h4444, 1);

        // Reset in the middle of an access, then a stray acknowledge.
        exp_req.push_back('{a: 24'h020007, wr: 1'b0, be: 2'b11, wdata: 16'h0000});
        @(posedge CLK) #1;
        sdr1.SDR_A = 17'h00007; sdr1.SDR_DO = 16'h0000; sdr1.SDR_RD = 1'b1; sdr1.SDR_CS = 1'b1;
        @(posedge CLK) #1;
        @(posedge CLK) #1;
        drop_strobes();
        RST_N = 1'b0;
        #1 check_all_zero("midreset");
        @(posedge CLK) #1;
        RST_N = 1'b1;
        @(posedge CLK) #1;
        mem1.MEM_ACK = 1'b1; mem1.MEM_RDATA = 16'h9999;
        @(posedge CLK) #1;
        mem1.MEM_ACK = 1'b0; mem1.MEM_RDATA = 16'h0000;
        chk("stray_ack_req", 32'(mem1.MEM_REQ), 32'd0);
        chk("stray_ack_wait", 32'(sdr1.SDR_WAIT), 32'd0);
        chk("stray_ack_di", 32'(sdr1.SDR_DI), 32'd0);
        do_access(17'h00008, 16'h0000, 2'b00, 1, 1,  16'h8888, 0,   0,    24'h020008, 2'b11, 0, 16'h8888, 0);

        // 17-bit memory channel with zero offset: address passes straight through.
        @(posedge CLK) #1;
        sdr2.SDR_A = 17'h1ABCD; sdr2.SDR_RD = 1'b1; sdr2.SDR_CS = 1'b1;
        @(posedge CLK) #1;
        chk("pass_req", 32'(mem2.MEM_REQ), 32'd1);
        chk("pass_mem_a", 32'(mem2.MEM_A), 32'h0001ABCD);
        mem2.MEM_ACK = 1'b1; mem2.MEM_RDATA = 16'h2222;
        @(posedge CLK) #1;
        mem2.MEM_ACK = 1'b0; mem2.MEM_RDATA = 16'h0000;
        chk("pass_wait", 32'(sdr2.SDR_WAIT), 32'd0);
        chk("pass_di", 32'(sdr2.SDR_DI), 32'h00002222);
        chk("pass_err", 32'(err2), 32'd0);
        sdr2.SDR_CS = 1'b0; sdr2.SDR_RD = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        chk("req_queue_drained", 32'(exp_req.size()), 32'd0);
        chk("cmp_queue_drained", 32'(exp_cmp.size()), 32'd0);
        chk("req_count", 32'(n_req), 32'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
